// File: rtl/xillybus_mem_8_if.sv
// Signal bundle between the Xillybus core and the mem_8 responder (seekable read/write stream pair).
// The master modport is the core side; the slave modport is the user-side responder.
interface xillybus_mem_8_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] user_mem_8_addr;
  logic              user_mem_8_addr_update;
  logic              user_r_mem_8_open;
  logic              user_r_mem_8_rden;
  logic [DATA_W-1:0] user_r_mem_8_data;
  logic              user_r_mem_8_empty;
  logic              user_r_mem_8_eof;
  logic              user_w_mem_8_open;
  logic              user_w_mem_8_wren;
  logic [DATA_W-1:0] user_w_mem_8_data;
  logic              user_w_mem_8_full;

  modport master (
    output user_mem_8_addr, user_mem_8_addr_update,
    output user_r_mem_8_open, user_r_mem_8_rden,
    input  user_r_mem_8_data, user_r_mem_8_empty, user_r_mem_8_eof,
    output user_w_mem_8_open, user_w_mem_8_wren, user_w_mem_8_data,
    input  user_w_mem_8_full
  );

  modport slave (
    input  user_mem_8_addr, user_mem_8_addr_update,
    input  user_r_mem_8_open, user_r_mem_8_rden,
    output user_r_mem_8_data, user_r_mem_8_empty, user_r_mem_8_eof,
    input  user_w_mem_8_open, user_w_mem_8_wren, user_w_mem_8_data,
    output user_w_mem_8_full
  );
endinterface

// File: rtl/xillybus_mem_8_responder.sv
// DEPTH x DATA_W register file behind the Xillybus mem_8 seekable stream pair, with an app read port.
// Optional XILLY_MEM8_EOF_AT_END_EN: reading the last entry raises empty/eof instead of wrapping.
module xillybus_mem_8_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                bus_clk,
  input  logic                bus_rst,
  xillybus_mem_8_if.slave     core,
  input  logic [ADDR_W-1:0]   app_rd_addr,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic [15:0]         wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

`ifdef XILLY_MEM8_EOF_AT_END_EN
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_AT_END} state_t;
`else
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
`endif

  state_t            state_q, state_d;
  logic              open_prev_q, open_prev_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [DATA_W-1:0] app_rd_data_q, app_rd_data_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic rd_fire;
  logic open_rise;
  logic end_hit;
  logic unused_w_open;

  // The write side has no notion of open/close; writes are taken regardless.
  assign unused_w_open = core.user_w_mem_8_open;

  always_comb begin
    state_d       = state_q;
    open_prev_d   = core.user_r_mem_8_open;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    r_data_d      = r_data_q;
    wr_count_d    = wr_count_q;
    app_rd_data_d = mem_q[app_rd_addr];
    rd_fire       = core.user_r_mem_8_rden;
    open_rise     = core.user_r_mem_8_open && !open_prev_q;
    end_hit       = 1'b0;

`ifdef XILLY_MEM8_EOF_AT_END_EN
    rd_fire = core.user_r_mem_8_rden && (state_q != S_AT_END);
    case (state_q)
      S_IDLE:   if (open_rise) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (!core.user_r_mem_8_open) begin
          state_d = S_IDLE;
        end else if (rd_fire && (rd_ptr_q == LAST_ADDR) && !core.user_mem_8_addr_update) begin
          state_d = S_AT_END;
          end_hit = 1'b1;
        end
      end
      S_AT_END: begin
        if (!core.user_r_mem_8_open)           state_d = S_IDLE;
        else if (core.user_mem_8_addr_update)  state_d = S_ACTIVE;
      end
      default:  state_d = S_IDLE;
    endcase
`else
    case (state_q)
      S_IDLE:   if (open_rise) state_d = S_ACTIVE;
      S_ACTIVE: if (!core.user_r_mem_8_open) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`endif

    // Reads sample the pre-update pointer; the update then wins over the increment.
    if (rd_fire) r_data_d = mem_q[rd_ptr_q];
    if (core.user_mem_8_addr_update) rd_ptr_d = core.user_mem_8_addr;
    else if (rd_fire && !end_hit)    rd_ptr_d = rd_ptr_q + 1'b1;

    if (core.user_mem_8_addr_update)  wr_ptr_d = core.user_mem_8_addr;
    else if (core.user_w_mem_8_wren)  wr_ptr_d = wr_ptr_q + 1'b1;

    if (core.user_w_mem_8_wren && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_q       <= S_IDLE;
      open_prev_q   <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      r_data_q      <= '0;
      app_rd_data_q <= '0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      open_prev_q   <= open_prev_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      r_data_q      <= r_data_d;
      app_rd_data_q <= app_rd_data_d;
      wr_count_q    <= wr_count_d;
    end
  end

  // Storage is deliberately left out of reset; readers above see the pre-write contents.
  always_ff @(posedge bus_clk) begin
    if (core.user_w_mem_8_wren) mem_q[wr_ptr_q] <= core.user_w_mem_8_data;
  end

  assign core.user_r_mem_8_data = r_data_q;
  assign core.user_w_mem_8_full = 1'b0;
`ifdef XILLY_MEM8_EOF_AT_END_EN
  assign core.user_r_mem_8_empty = (state_q == S_AT_END);
  assign core.user_r_mem_8_eof   = (state_q == S_AT_END);
`else
  assign core.user_r_mem_8_empty = 1'b0;
  assign core.user_r_mem_8_eof   = 1'b0;
`endif
  assign app_rd_data = app_rd_data_q;
  assign wr_count    = wr_count_q;

endmodule
